// File: rtl/mem_bus_ctrl_pkg.sv
// Shared bus definitions: FSM states, peripheral addresses, TCTRL bit layout
// and the address-region decode used by the bus controller.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, READ, WRITE} busState_t;

  typedef enum logic [2:0] {
    REG_RAM, REG_SWITCH, REG_LED, REG_TCOUNT, REG_TCTRL, REG_RSVD
  } region_t;

  localparam logic [15:0] ADDR_SWITCH = 16'hFFFC;
  localparam logic [15:0] ADDR_LED    = 16'hFFFD;
  localparam logic [15:0] ADDR_TCOUNT = 16'hFFFE;
  localparam logic [15:0] ADDR_TCTRL  = 16'hFFFF;

  localparam int TCTRL_EN  = 0;
  localparam int TCTRL_OVF = 1;
  localparam int TCTRL_IE  = 2;

  // RAM takes precedence so a large RAM_TOP simply shadows the peripherals.
  function automatic region_t decodeRegion(input logic [15:0] addr, input logic [15:0] ramTop);
    if (addr <= ramTop)            return REG_RAM;
    else if (addr == ADDR_SWITCH)  return REG_SWITCH;
    else if (addr == ADDR_LED)     return REG_LED;
    else if (addr == ADDR_TCOUNT)  return REG_TCOUNT;
    else if (addr == ADDR_TCTRL)   return REG_TCTRL;
    else                           return REG_RSVD;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_timer.sv
// Prescaled 16-bit timer with enable, sticky overflow flag (W1C) and
// interrupt enable; Irq is a pure AND of two flops.
module bus_timer
  import mem_bus_ctrl_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        countWr,
  input  logic        ctrlWr,
  input  logic [15:0] wrData,
  output logic [15:0] count,
  output logic [2:0]  ctrl,
  output logic        Irq
);

  localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

  logic [7:0] prescaler;
  logic       enable;
  logic       ovf;
  logic       irqEn;
  logic       tick;
  logic       wrap;

  assign tick = enable && (prescaler == PS_MAX);
  // A count load pre-empts the tick, so it can never produce a wrap.
  assign wrap = tick && (count == 16'hFFFF) && !countWr;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count     <= '0;
      prescaler <= '0;
      enable    <= 1'b0;
      ovf       <= 1'b0;
      irqEn     <= 1'b0;
    end else begin
      if (countWr) begin
        count     <= wrData;
        prescaler <= '0;
      end else if (enable) begin
        if (tick) begin
          prescaler <= '0;
          count     <= count + 16'd1;
        end else begin
          prescaler <= prescaler + 8'd1;
        end
      end
      if (ctrlWr) begin
        enable <= wrData[TCTRL_EN];
        irqEn  <= wrData[TCTRL_IE];
      end
      if (wrap)
        ovf <= 1'b1;
      else if (ctrlWr && wrData[TCTRL_OVF])
        ovf <= 1'b0;
    end
  end

  assign ctrl = {irqEn, ovf, enable};
  assign Irq  = ovf & irqEn;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: latches the address on ALE, drives the external RAM
// strobes and hosts the switch/LED/timer peripherals at the top of the map.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter logic [15:0] RAM_TOP  = 16'hBFFF,
  parameter int          PRESCALE = 16
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        ALE,
  input  logic        nME,
  input  logic        nOE,
  input  logic        nWE,
  input  logic [15:0] SysBusOut,
  output logic [15:0] SysBusIn,
  output logic [15:0] RamAddr,
  output logic [15:0] RamWData,
  input  logic [15:0] RamRData,
  output logic        nRamCS,
  output logic        nRamOE,
  output logic        nRamWE,
  input  logic [7:0]  Switches,
  output logic [7:0]  Leds,
  output logic        Irq,
  output logic        BusErr
);

  busState_t   state, nextState;
  logic [15:0] addrReg;
  logic [7:0]  swSync1, swSync2;
  region_t     region;
  logic        writeCommit;
  logic [15:0] tCount;
  logic [2:0]  tCtrl;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      addrReg <= '0;
      BusErr  <= 1'b0;
      Leds    <= '0;
      swSync1 <= '0;
      swSync2 <= '0;
    end else begin
      state   <= nextState;
      swSync1 <= Switches;
      swSync2 <= swSync1;
      if (ALE)
        addrReg <= SysBusOut;
      if (state == IDLE && !nME)
        BusErr <= 1'b1;
      if (writeCommit && region == REG_LED)
        Leds <= SysBusOut[7:0];
    end
  end

  always_comb begin
    nextState = state;
    if (ALE) begin
      nextState = ADDR;
    end else begin
      case (state)
        ADDR: begin
          if (!nME && !nWE)      nextState = WRITE;
          else if (!nME && !nOE) nextState = READ;
        end
        READ: begin
          if (nME)       nextState = IDLE;
          else if (!nWE) nextState = WRITE;
        end
        WRITE: begin
          if (nME) nextState = IDLE;
        end
        default: nextState = state;
      endcase
    end
  end

  // Peripheral writes fire only on the edge that enters WRITE, so a long
  // nWE pulse still commits exactly once.
  assign writeCommit = (nextState == WRITE) && (state != WRITE);

  assign region   = decodeRegion(addrReg, RAM_TOP);
  assign RamAddr  = addrReg;
  assign RamWData = SysBusOut;
  assign nRamCS   = !((state != IDLE) && !nME && (region == REG_RAM));
  assign nRamOE   = nOE | nRamCS;
  assign nRamWE   = nWE | nRamCS;

  always_comb begin
    SysBusIn = 16'h0000;
    case (region)
      REG_RAM:    SysBusIn = RamRData;
      REG_SWITCH: SysBusIn = {8'h00, swSync2};
      REG_LED:    SysBusIn = {8'h00, Leds};
      REG_TCOUNT: SysBusIn = tCount;
      REG_TCTRL:  SysBusIn = {13'h0000, tCtrl};
      default:    SysBusIn = 16'h0000;
    endcase
  end

  bus_timer #(.PRESCALE(PRESCALE)) uTimer (
    .Clock   (Clock),
    .nReset  (nReset),
    .countWr (writeCommit && region == REG_TCOUNT),
    .ctrlWr  (writeCommit && region == REG_TCTRL),
    .wrData  (SysBusOut),
    .count   (tCount),
    .ctrl    (tCtrl),
    .Irq     (Irq)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed table, corner sequences and random bus
// transactions against a transaction-level model of the memory map and timer.
module tb_mem_bus_ctrl;

  localparam int PS = 4;

  logic        Clock, nReset;
  logic        ALE, nME, nOE, nWE;
  logic [15:0] SysBusOut, SysBusIn, RamAddr, RamWData, RamRData;
  logic        nRamCS, nRamOE, nRamWE;
  logic [7:0]  Switches, Leds;
  logic        Irq, BusErr;

  mem_bus_ctrl #(.RAM_TOP(16'hBFFF), .PRESCALE(PS)) dut (
    .Clock(Clock), .nReset(nReset), .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE),
    .SysBusOut(SysBusOut), .SysBusIn(SysBusIn), .RamAddr(RamAddr),
    .RamWData(RamWData), .RamRData(RamRData), .nRamCS(nRamCS),
    .nRamOE(nRamOE), .nRamWE(nRamWE), .Switches(Switches), .Leds(Leds),
    .Irq(Irq), .BusErr(BusErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int nVec = 0;
  int nMis = 0;

  // Reference model state
  logic [7:0]  mLeds, mSw1, mSw2;
  logic [15:0] mCnt;
  int          mPre;
  logic        mEn, mOvf, mIe, mBusErr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isRam(input logic [15:0] a);
    return a <= 16'hBFFF;
  endfunction

  function automatic logic [15:0] expRead(input logic [15:0] a);
    if (isRam(a))         return RamRData;
    else if (a == 16'hFFFC) return {8'h00, mSw2};
    else if (a == 16'hFFFD) return {8'h00, mLeds};
    else if (a == 16'hFFFE) return mCnt;
    else if (a == 16'hFFFF) return {13'h0, mIe, mOvf, mEn};
    else                  return 16'h0000;
  endfunction

  task automatic mReset();
    mLeds = '0; mSw1 = '0; mSw2 = '0; mCnt = '0; mPre = 0;
    mEn = 0; mOvf = 0; mIe = 0; mBusErr = 0;
  endtask

  task automatic drive(input logic ale, nme, noe, nwe, input logic [15:0] bus);
    ALE = ale; nME = nme; nOE = noe; nWE = nwe; SysBusOut = bus;
  endtask

  // One clock edge; commit marks the edge on which a register write lands.
  task automatic step(input bit commit, input logic [15:0] cA, input logic [15:0] cD);
    bit wrapNow;
    @(posedge Clock);
    wrapNow = 0;
    if (commit && cA == 16'hFFFE) begin
      mCnt = cD; mPre = 0;
    end else if (mEn) begin
      if (mPre == PS - 1) begin
        mPre = 0;
        if (mCnt == 16'hFFFF) wrapNow = 1;
        mCnt = mCnt + 16'd1;
      end else mPre++;
    end
    if (commit && cA == 16'hFFFF) begin
      mEn = cD[0]; mIe = cD[2];
      if (cD[1]) mOvf = 0;
    end
    if (wrapNow) mOvf = 1;
    if (commit && cA == 16'hFFFD) mLeds = cD[7:0];
    mSw2 = mSw1; mSw1 = Switches;
    #1;
  endtask

  task automatic readTxn(input logic [15:0] a, output logic [15:0] got);
    drive(1, 1, 1, 1, a); step(0, 0, 0);
    RamRData = 16'($urandom);
    drive(0, 0, 0, 1, 16'($urandom));
    #3;
    chk("rdAddr", RamAddr, a);
    chk("rdCS", {15'h0, nRamCS}, {15'h0, !isRam(a)});
    chk("rdOE", {15'h0, nRamOE}, {15'h0, !isRam(a)});
    chk("rdWE", {15'h0, nRamWE}, 16'h1);
    chk("rdData", SysBusIn, expRead(a));
    got = SysBusIn;
    step(0, 0, 0);
    drive(0, 1, 1, 1, 16'h0);
    #3 chk("rdEndCS", {15'h0, nRamCS}, 16'h1);
    step(0, 0, 0);
  endtask

  task automatic writeTxn(input logic [15:0] a, input logic [15:0] d);
    drive(1, 1, 1, 1, a); step(0, 0, 0);
    drive(0, 0, 1, 1, d);
    #3;
    chk("wrHoldCS", {15'h0, nRamCS}, {15'h0, !isRam(a)});
    chk("wrHoldWE", {15'h0, nRamWE}, 16'h1);
    step(0, 0, 0);
    drive(0, 0, 1, 0, d);
    #3;
    chk("wrCS", {15'h0, nRamCS}, {15'h0, !isRam(a)});
    chk("wrWE", {15'h0, nRamWE}, {15'h0, !isRam(a)});
    chk("wrData", RamWData, d);
    step(1, a, d);
    // Different data on the second strobe cycle exposes a double commit.
    drive(0, 0, 1, 0, ~d);
    step(0, 0, 0);
    drive(0, 1, 1, 1, 16'h0);
    step(0, 0, 0);
    chk("leds", {8'h0, Leds}, {8'h0, mLeds});
    chk("irq", {15'h0, Irq}, {15'h0, mOvf & mIe});
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRd;
  } vec_t;

  vec_t tbl[7];
  logic [15:0] got;

  initial begin
    tbl[0] = '{16'hFFFD, 16'h00A5, 16'h00A5};
    tbl[1] = '{16'hFFFD, 16'h5A3C, 16'h003C};
    tbl[2] = '{16'hFFFE, 16'hBEEF, 16'hBEEF};
    tbl[3] = '{16'hFFFF, 16'h0004, 16'h0004};
    tbl[4] = '{16'hFFFF, 16'h0000, 16'h0000};
    tbl[5] = '{16'hC000, 16'h1111, 16'h0000};
    tbl[6] = '{16'hFFFC, 16'h00FF, 16'h003C};

    nReset = 0; Switches = 8'h00; RamRData = 16'h0;
    drive(0, 1, 1, 1, 16'h0);
    mReset();
    #12;
    chk("rstLeds", {8'h0, Leds}, 16'h0);
    chk("rstBusErr", {15'h0, BusErr}, 16'h0);
    chk("rstIrq", {15'h0, Irq}, 16'h0);
    chk("rstCS", {15'h0, nRamCS}, 16'h1);
    chk("rstAddr", RamAddr, 16'h0);
    @(negedge Clock) nReset = 1;
    step(0, 0, 0);

    // nME without ALE from IDLE is a protocol error
    drive(0, 0, 0, 1, 16'h0);
    #3 chk("errCS", {15'h0, nRamCS}, 16'h1);
    step(0, 0, 0);
    mBusErr = 1;
    chk("busErr", {15'h0, BusErr}, {15'h0, mBusErr});
    drive(0, 1, 1, 1, 16'h0);
    step(0, 0, 0);

    // Fetch from RAM
    readTxn(16'h0010, got);
    chk("busErrSticky", {15'h0, BusErr}, 16'h1);
    @(negedge Clock) nReset = 0;
    #1 chk("busErrClr", {15'h0, BusErr}, 16'h0);
    mReset();
    @(negedge Clock) nReset = 1;
    Switches = 8'h3C;
    step(0, 0, 0);
    step(0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      writeTxn(tbl[i].addr, tbl[i].wdata);
      readTxn(tbl[i].addr, got);
      chk($sformatf("tbl%0d", i), got, tbl[i].expRd);
    end

    // Timer wrap with prescale 4: 8 enabled edges from 0xFFFE
    writeTxn(16'hFFFE, 16'hFFFE);
    writeTxn(16'hFFFF, 16'h0005);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("irqEarly", {15'h0, Irq}, 16'h0);
    step(0, 0, 0);
    chk("irqSet", {15'h0, Irq}, 16'h1);
    readTxn(16'hFFFE, got);
    chk("cntWrapped", got, 16'h0000);
    readTxn(16'hFFFF, got);
    chk("ctrlOvf", got, 16'h0007);
    writeTxn(16'hFFFF, 16'h0007);
    chk("irqCleared", {15'h0, Irq}, 16'h0);

    // Reset in the middle of a RAM write
    writeTxn(16'hFFFF, 16'h0000);
    drive(1, 1, 1, 1, 16'h0100); step(0, 0, 0);
    drive(0, 0, 1, 0, 16'h1234);
    #2 chk("midCS", {15'h0, nRamCS}, 16'h0);
    nReset = 0;
    #1 chk("rstMidCS", {15'h0, nRamCS}, 16'h1);
    mReset();
    @(negedge Clock) drive(0, 1, 1, 1, 16'h0);
    @(negedge Clock) nReset = 1;
    step(0, 0, 0);

    // Reset before a TCOUNT write commits discards it
    writeTxn(16'hFFFE, 16'h00AA);
    drive(1, 1, 1, 1, 16'hFFFE); step(0, 0, 0);
    drive(0, 0, 1, 0, 16'h1234);
    #2 nReset = 0;
    #1 chk("rstTcCS", {15'h0, nRamCS}, 16'h1);
    mReset();
    @(negedge Clock) drive(0, 1, 1, 1, 16'h0);
    @(negedge Clock) nReset = 1;
    step(0, 0, 0);
    readTxn(16'hFFFE, got);
    chk("rstCount", got, 16'h0000);

    // Random transactions
    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      int r;
      r = int'($urandom_range(0, 5));
      if (r < 2)       a = 16'($urandom_range(0, 16'hBFFF));
      else if (r == 2) a = 16'($urandom_range(16'hC000, 16'hFFFB));
      else             a = 16'hFFFC + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) Switches = 8'($urandom);
      if ($urandom_range(0, 1) == 1) writeTxn(a, 16'($urandom));
      else                           readTxn(a, got);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) step(0, 0, 0);
      chk("rndIrq", {15'h0, Irq}, {15'h0, mOvf & mIe});
      chk("rndBusErr", {15'h0, BusErr}, {15'h0, mBusErr});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter RAM_TOP, default 16'hBFFF, highest RAM address; RAM region is 0x0000..RAM_TOP.
REQ-002 SHALL have parameter PRESCALE, default 16, Clock cycles per timer tick (range 1..256).
REQ-003 SHALL have port Clock  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ALE, nME, nOE, nWE  input  1 each  bus strobes from the control unit.
REQ-006 SHALL have port SysBusOut  input  16  address during ALE, write data otherwise.
REQ-007 SHALL have port SysBusIn  output  16  read data to the core.
REQ-008 SHALL have ports RamAddr  output  16,  RamWData  output  16,  RamRData  input  16  external RAM buses.
REQ-009 SHALL have ports nRamCS, nRamOE, nRamWE  output  1 each  external RAM strobes, active-low.
REQ-010 SHALL have ports Switches  input  8  asynchronous board switches,  Leds  output  8  LED register.
REQ-011 SHALL have ports Irq  output  1  timer interrupt,  BusErr  output  1  sticky protocol error.

Function
REQ-012 SHALL run FSM states IDLE, ADDR, READ, WRITE.
REQ-013 ALE=1 in any state SHALL latch SysBusOut into the address register and go to ADDR (ALE has priority over all other transitions).
REQ-014 ADDR SHALL go to WRITE when nME=0 and nWE=0, else to READ when nME=0 and nOE=0, else stay in ADDR (nME=0 with nOE=nWE=1 holds ADDR).
REQ-015 READ SHALL go to WRITE when nWE=0; READ and WRITE SHALL return to IDLE when nME=1.
REQ-016 nME=0 while in IDLE SHALL set BusErr, held until reset; the FSM stays in IDLE.
REQ-017 Address decode: RAM when addr<=RAM_TOP; 0xFFFC SWITCH (RO); 0xFFFD LED (RW); 0xFFFE TCOUNT (RW); 0xFFFF TCTRL (RW); anything else reserved.
REQ-018 RamAddr SHALL equal the latched address; RamWData SHALL equal SysBusOut.
REQ-019 nRamCS SHALL be 0 only when FSM is not IDLE, nME=0 and the address is in RAM; nRamOE = nOE OR nRamCS; nRamWE = nWE OR nRamCS (combinational).
REQ-020 SysBusIn SHALL be combinational: RamRData for RAM, {8'h00, synchronised switches}, {8'h00, Leds}, timer count, {13'h0, TCTRL[2:0]} for peripherals, 16'h0000 for reserved.
REQ-021 A peripheral register write SHALL commit exactly once, on the clock edge at which the FSM enters WRITE; writes to SWITCH/reserved are ignored.
REQ-022 Switches SHALL pass through a two-flop synchroniser before readback.
REQ-023 TCTRL bit0 = timer enable, bit1 = overflow flag, bit2 = interrupt enable; writing bit1=1 clears the flag (W1C), bit1=0 leaves it.
REQ-024 With enable=1 the prescaler SHALL count 0..PRESCALE-1; on wrap the count SHALL increment by 1 modulo 2^16.
REQ-025 Count wrap 0xFFFF->0x0000 SHALL set the overflow flag; set and W1C clear in the same cycle: set wins.
REQ-026 A TCOUNT write SHALL load the count and zero the prescaler, taking priority over a simultaneous tick.
REQ-027 Irq SHALL equal overflow flag AND interrupt enable, registered-source only (no glitch path from strobes).
REQ-028 Enable=0 SHALL freeze count and prescaler.

Reset
REQ-029 nReset low SHALL asynchronously force FSM=IDLE, address=0, Leds=0, count=0, prescaler=0, TCTRL=0, synchroniser=0, BusErr=0, hence Irq=0.
REQ-030 Reset mid-access SHALL drop nRamCS high immediately (via IDLE) and discard the pending peripheral write.

Structure
REQ-031 Address constants (SWITCH/LED/TCOUNT/TCTRL addresses), TCTRL bit indices and the bus-state enum SHALL live in the shared opcodes package.
REQ-032 The timer (count, prescaler, TCTRL, Irq) SHALL be a sub-module named bus_timer; all else stays in mem_bus_ctrl.

Verification
REQ-033 Fetch: ALE with 0x0010, then nME=0,nOE=0 -> RamAddr=0x0010, nRamCS=0, nRamOE=0, nRamWE=1, SysBusIn=RamRData.
REQ-034 Store: ALE 0xFFFD, nME=0 nOE=1 nWE=1 one cycle, then nWE=0 two cycles with data 0x00A5 -> Leds=0xA5 written once, nRamCS stays 1.
REQ-035 Timer: PRESCALE=4, write TCOUNT=0xFFFE, TCTRL=0x5 -> after 8 cycles count=0x0000, overflow=1, Irq=1; write TCTRL=0x7 -> Irq=0 unless wrap same cycle.
REQ-036 Protocol: nME=0 without prior ALE after reset -> BusErr=1, no RAM strobe, persists until nReset.
REQ-037 Reserved read 0xC000 -> SysBusIn=0x0000, nRamCS=1; Switches=0x3C -> readback 0x003C after two clocks.
REQ-038 Reset asserted during WRITE to 0xFFFE -> count=0, FSM IDLE, nRamCS=1 asynchronously.
